sobel_window_ctrl: RTL

//  Raster-scan controller that feeds the Sobel gradient units (vertical_gradient and its horizontal twin).

---
 rtl/sobel_window_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sobel_window_ctrl.sv
// Raster-scan window builder for the Sobel gradient units: two line buffers,
// a 3x3 pixel window and a one-deep valid/accept output stage.
module sobel_window_ctrl #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        frame_start,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [71:0] window,
  output logic        start_calculations,
  input  logic        calc_accept,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(2);
  localparam logic [RW-1:0] ROW_MIN  = RW'(2);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StStream = 2'd1;
  localparam logic [1:0] StDrain  = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [8:0][7:0] win_q, win_d;
  logic            start_q, start_d;
  logic            done_q, done_d;

  logic [7:0] linebuf0 [IMG_W];
  logic [7:0] linebuf1 [IMG_W];
  logic [7:0] lb0_rd, lb1_rd;
  logic       abort, accept, last_pix;

  assign pix_ready = (state_q == StStream) && (!start_q || calc_accept);
  assign abort     = frame_start && ((state_q == StStream) || (state_q == StDrain));
  // An abort in the same cycle as a handshake discards that pixel.
  assign accept    = pix_valid && pix_ready && !abort;
  assign last_pix  = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign lb0_rd    = linebuf0[col_q];
  assign lb1_rd    = linebuf1[col_q];

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    start_d = start_q;

    case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d = StStream;
          row_d   = '0;
          col_d   = '0;
        end
      end
      StStream: if (accept && last_pix) state_d = StDrain;
      StDrain:  if (!start_q || calc_accept) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (start_q && calc_accept) start_d = 1'b0;

    if (accept) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb1_rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb0_rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pix_in;
      start_d  = (row_q >= ROW_MIN) && (col_q >= COL_MIN);
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    if (abort) begin
      state_d = StStream;
      row_d   = '0;
      col_d   = '0;
      start_d = 1'b0;
    end

    // frame_done is high for exactly the cycle spent in DONE.
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  // Line buffers are plain storage; border suppression hides stale contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      linebuf1[col_q] <= lb0_rd;
      linebuf0[col_q] <= pix_in;
    end
  end

  assign window             = win_q;
  assign start_calculations = start_q;
  assign busy               = (state_q != StIdle);
  assign frame_done         = done_q;

endmodule
